// File: rtl/ransac_fixed_pkg.sv
// Fixed-point types shared by the RANSAC datapath: Q16.16 values, FMA opcodes and
// the tag that travels alongside each FMA operation.
package ransac_fixed;

  localparam int unsigned VALUE_BITS = 32;
  localparam int unsigned FRAC_BITS  = 16;

  typedef logic signed [VALUE_BITS-1:0] fixed_t;

  typedef enum logic [1:0] {
    POS_A_POS_C = 2'd0,
    POS_A_NEG_C = 2'd1,
    NEG_A_POS_C = 2'd2,
    NEG_A_NEG_C = 2'd3
  } fma_opcode_t;

  typedef fixed_t [2:0] vector3_t;

  typedef logic [1:0] dot_step_t;

  typedef struct packed {
    logic      valid;
    dot_step_t step;
  } fma_tag_t;

  localparam dot_step_t LAST_STEP = 2'd2;
  localparam fixed_t    FIXED_MIN = fixed_t'({1'b1, (VALUE_BITS-1)'(0)});

  function automatic int unsigned value_bits();
    return VALUE_BITS;
  endfunction

  // Two's-complement magnitude; FIXED_MIN maps onto itself.
  function automatic fixed_t fixed_abs(input fixed_t v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/plane_distance_sequencer.sv
// Point-to-plane distance d = n.p - offset computed as three chained FMA operations
// on an external fixed-latency FMA, followed by an |d| <= threshold inlier test.
module plane_distance_sequencer
  import ransac_fixed::*;
#(
  parameter int unsigned FMA_LATENCY = value_bits() / 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  vector3_t    point,
  input  vector3_t    normal,
  input  fixed_t      offset,
  input  fixed_t      threshold,
  output logic        out_valid,
  input  logic        out_ready,
  output fixed_t      distance,
  output logic        inlier,
  output fma_opcode_t fma_opcode,
  output fixed_t      fma_a,
  output fixed_t      fma_b,
  output fixed_t      fma_c,
  output fma_tag_t    fma_tag_o,
  input  fixed_t      fma_r,
  input  fma_tag_t    fma_tag_i,
  output logic        error
);

  localparam int unsigned CNT_W = $clog2(FMA_LATENCY + 2);

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  seq_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dot_step_t   step_q, step_d;
  vector3_t    n_q, n_d, p_q, p_d;
  fixed_t      thr_q, thr_d;
  fixed_t      dist_q, dist_d;
  logic        inlier_q, inlier_d;
  fma_opcode_t op_q, op_d;
  fixed_t      a_q, a_d, b_q, b_d, c_q, c_d;
  fma_tag_t    tag_q, tag_d;
  logic        err_q, err_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic        accept;
  logic        tag_hit;
  logic        load_issue;
  vector3_t    src_n, src_p;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= CNT_W'(FMA_LATENCY);
      step_q      <= '0;
      n_q         <= '0;
      p_q         <= '0;
      thr_q       <= '0;
      dist_q      <= '0;
      inlier_q    <= 1'b0;
      op_q        <= POS_A_POS_C;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      n_q         <= n_d;
      p_q         <= p_d;
      thr_q       <= thr_d;
      dist_q      <= dist_d;
      inlier_q    <= inlier_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    n_d        = n_q;
    p_d        = p_q;
    thr_d      = thr_q;
    dist_d     = dist_q;
    inlier_d   = inlier_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    tag_d      = '{valid: 1'b0, step: tag_q.step};
    err_d      = err_q;
    load_issue = 1'b0;

    accept  = (state_q == ST_IDLE) && in_valid && in_ready_q;
    tag_hit = fma_tag_i.valid && (fma_tag_i.step == step_q);
    src_n   = accept ? normal : n_q;
    src_p   = accept ? point  : p_q;

    case (state_q)
      ST_FLUSH: begin
        // Returning tags are stale pipeline contents here and are not errors.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (fma_tag_i.valid) err_d = 1'b1;
        if (accept) begin
          n_d        = normal;
          p_d        = point;
          thr_d      = threshold;
          step_d     = '0;
          state_d    = ST_ISSUE;
          load_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (fma_tag_i.valid) err_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fma_tag_i.valid && !tag_hit) err_d = 1'b1;
        if (tag_hit) begin
          if (step_q != LAST_STEP) begin
            step_d     = step_q + 2'd1;
            state_d    = ST_ISSUE;
            load_issue = 1'b1;
          end else begin
            dist_d   = fma_r;
            inlier_d = (fma_r != FIXED_MIN) && (fixed_abs(fma_r) <= thr_q);
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (fma_tag_i.valid) err_d = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase

    // Operands are registered on the edge entering ISSUE so the FMA sees them during ISSUE;
    // the running sum is taken straight from the result being captured on that edge.
    if (load_issue) begin
      tag_d = '{valid: 1'b1, step: step_d};
      op_d  = (step_d == '0) ? POS_A_NEG_C : POS_A_POS_C;
      a_d   = src_n[step_d];
      b_d   = src_p[step_d];
      c_d   = (step_d == '0) ? offset : fma_r;
    end

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign distance   = dist_q;
  assign inlier     = inlier_q;
  assign fma_opcode = op_q;
  assign fma_a      = a_q;
  assign fma_b      = b_q;
  assign fma_c      = c_q;
  assign fma_tag_o  = tag_q;
  assign error      = err_q;

endmodule

// File: tb/tb_plane_distance_sequencer.sv
// Directed bench: Q16.16 FMA model behind the sequencer, vector table plus reset,
// backpressure and tag-fault sequences.
`timescale 1ns/1ps
module tb_plane_distance_sequencer;
  import ransac_fixed::*;

  localparam int unsigned L = 4;

  localparam fixed_t F0    = 32'sh0000_0000;
  localparam fixed_t F1    = 32'sh0001_0000;
  localparam fixed_t F2    = 32'sh0002_0000;
  localparam fixed_t F2P5  = 32'sh0002_8000;
  localparam fixed_t F3    = 32'sh0003_0000;
  localparam fixed_t F5    = 32'sh0005_0000;
  localparam fixed_t F7    = 32'sh0007_0000;
  localparam fixed_t FP5   = 32'sh0000_8000;
  localparam fixed_t FP25  = 32'sh0000_4000;
  localparam fixed_t F1P5  = 32'sh0001_8000;
  localparam fixed_t F4    = 32'sh0004_0000;
  localparam fixed_t FM6   = 32'shFFFA_0000;
  localparam fixed_t FM2   = 32'shFFFE_0000;
  localparam fixed_t FM1   = 32'shFFFF_0000;
  localparam fixed_t FMP25 = 32'shFFFF_C000;
  localparam fixed_t FMP75 = 32'shFFFF_4000;
  localparam fixed_t FMAXP = 32'sh7FFF_FFFF;
  localparam fixed_t FBIG  = 32'sh7FFF_0000;
  localparam fixed_t FMIN  = 32'sh8000_0000;
  localparam fixed_t FWRAP = 32'sh8001_0000;
  localparam fixed_t FJUST = 32'sh0001_FFFF;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready, inlier, error;
  vector3_t    point, normal;
  fixed_t      offset, threshold, distance, fma_a, fma_b, fma_c, fma_r;
  fma_opcode_t fma_opcode;
  fma_tag_t    fma_tag_o, fma_tag_i;

  logic        inj;
  fma_tag_t    inj_tag;
  fixed_t      inj_r;
  fixed_t      pr [L];
  fma_tag_t    pt [L];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int ov_cnt = 0;

  typedef struct {
    vector3_t n;
    vector3_t p;
    fixed_t   off;
    fixed_t   thr;
    fixed_t   ed;
    logic     ei;
  } vec_t;

  vec_t tv [8];

  always #5 clock = ~clock;

  plane_distance_sequencer #(.FMA_LATENCY(L)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .point(point), .normal(normal), .offset(offset), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready),
    .distance(distance), .inlier(inlier),
    .fma_opcode(fma_opcode), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_tag_o(fma_tag_o), .fma_r(fma_r), .fma_tag_i(fma_tag_i),
    .error(error)
  );

  function automatic fixed_t fma_model(input fma_opcode_t op, input fixed_t a,
                                       input fixed_t b, input fixed_t c);
    logic signed [63:0] prod;
    fixed_t m;
    prod = a * b;
    m = fixed_t'(prod >>> FRAC_BITS);
    case (op)
      POS_A_POS_C: return m + c;
      POS_A_NEG_C: return m - c;
      NEG_A_POS_C: return c - m;
      default:     return -m - c;
    endcase
  endfunction

  // FMA pipeline is deliberately not reset so stale results survive a sequencer reset.
  always @(posedge clock) begin
    pr[0] <= fma_model(fma_opcode, fma_a, fma_b, fma_c);
    pt[0] <= fma_tag_o;
    for (int i = 1; i < int'(L); i++) begin
      pr[i] <= pr[i-1];
      pt[i] <= pt[i-1];
    end
  end

  always_comb begin
    fma_r     = inj ? inj_r   : pr[L-1];
    fma_tag_i = inj ? inj_tag : pt[L-1];
  end

  always @(posedge clock) begin
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
  end

  function automatic vector3_t mkv(input fixed_t x0, input fixed_t x1, input fixed_t x2);
    vector3_t v;
    v[0] = x0;
    v[1] = x1;
    v[2] = x2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Caller must be at a falling edge; returns at the falling edge after the output handshake.
  task automatic run_point(input int id, input vec_t v, input bit inject, input int stall);
    int k;
    fixed_t d0;
    logic i0;
    int h0;
    k = 0;
    out_ready = (stall == 0);
    while (!in_ready && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk($sformatf("in_ready_wait[%0d]", id), 32'(in_ready), 32'd1);
    normal    = v.n;
    point     = v.p;
    offset    = v.off;
    threshold = v.thr;
    in_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      inj = inject && (k == 1);
      @(negedge clock);
      k++;
    end
    inj = 1'b0;
    chk($sformatf("latency[%0d]", id), 32'(k), 32'(3*L + 3));
    chk($sformatf("in_ready_done[%0d]", id), 32'(in_ready), 32'd0);
    chk($sformatf("distance[%0d]", id), 32'(distance), 32'(v.ed));
    chk($sformatf("inlier[%0d]", id), 32'(inlier), 32'(v.ei));
    d0 = distance;
    i0 = inlier;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      chk($sformatf("stall_valid[%0d]", id), 32'(out_valid), 32'd1);
      chk($sformatf("stall_dist[%0d]", id), 32'(distance), 32'(d0));
      chk($sformatf("stall_inl[%0d]", id), 32'(inlier), 32'(i0));
      chk($sformatf("stall_rdy[%0d]", id), 32'(in_ready), 32'd0);
    end
    h0 = hs_cnt;
    out_ready = 1'b1;
    @(negedge clock);
    chk($sformatf("valid_drop[%0d]", id), 32'(out_valid), 32'd0);
    chk($sformatf("ready_rise[%0d]", id), 32'(in_ready), 32'd1);
    chk($sformatf("handshakes[%0d]", id), 32'(hs_cnt), 32'(h0 + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0;
    tv[0] = '{mkv(F1, F0, F0),     mkv(F3, F5, F7),        F1,   F2P5,  F2,    1'b1};
    tv[1] = '{mkv(F0, FP5, FP5),   mkv(F0, F2, FM6),       F0,   F1,    FM2,   1'b0};
    tv[2] = '{mkv(F0, FP5, FP5),   mkv(F0, F2, FM6),       F0,   F2,    FM2,   1'b1};
    tv[3] = '{mkv(F1, F0, F0),     mkv(F0, F0, F0),        F0,   FM1,   F0,    1'b0};
    tv[4] = '{mkv(F1, F0, F0),     mkv(F0, F0, F0),        F0,   F0,    F0,    1'b1};
    tv[5] = '{mkv(F0, F0, F0),     mkv(F0, F0, F0),        FMIN, FMAXP, FMIN,  1'b0};
    tv[6] = '{mkv(F1, F1, F0),     mkv(FBIG, F2, F0),      F0,   FMAXP, FWRAP, 1'b1};
    tv[7] = '{mkv(FP5, FMP25, F2), mkv(F1P5, F4, FMP75),   FP25, FJUST, FM2,   1'b0};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    point     = '0;
    normal    = '0;
    offset    = '0;
    threshold = '0;
    inj       = 1'b1;
    inj_tag   = '{valid: 1'b1, step: 2'd1};
    inj_r     = 32'sh1234_5678;

    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_tag_valid", 32'(fma_tag_o.valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_distance", 32'(distance), 32'd0);
    chk("rst_inlier", 32'(inlier), 32'd0);

    // Garbage tags throughout the flush window must not raise error.
    resetn = 1'b1;
    for (int i = 0; i <= int'(L); i++) begin
      inj_tag.step = 2'($urandom_range(0, 3));
      inj_r = fixed_t'($urandom);
      @(negedge clock);
      chk($sformatf("flush_ready[%0d]", i), 32'(in_ready), (i == int'(L)) ? 32'd1 : 32'd0);
    end
    inj = 1'b0;
    chk("flush_error", 32'(error), 32'd0);

    for (int i = 0; i < 8; i++) run_point(i, tv[i], 1'b0, 0);
    chk("table_error", 32'(error), 32'd0);

    run_point(10, tv[0], 1'b0, 20);

    // Reset while step 1 is inside the FMA; its tag returns on the first flush edge.
    normal    = tv[0].n;
    point     = tv[0].p;
    offset    = tv[0].off;
    threshold = tv[0].thr;
    in_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2*L) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_tag_valid", 32'(fma_tag_o.valid), 32'd0);
    chk("midrst_distance", 32'(distance), 32'd0);
    ov0 = ov_cnt;
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i <= int'(L); i++) begin
      @(negedge clock);
      chk($sformatf("reflush_ready[%0d]", i), 32'(in_ready), (i == int'(L)) ? 32'd1 : 32'd0);
    end
    chk("reflush_error", 32'(error), 32'd0);
    chk("reflush_no_valid", 32'(ov_cnt), 32'(ov0));
    run_point(11, tv[1], 1'b0, 0);

    chk("pre_fault_error", 32'(error), 32'd0);
    inj_tag = '{valid: 1'b1, step: 2'd2};
    inj_r   = 32'sh0BAD_0BAD;
    run_point(12, tv[6], 1'b1, 0);
    chk("fault_error", 32'(error), 32'd1);
    run_point(13, tv[7], 1'b0, 0);
    chk("fault_sticky", 32'(error), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
